// File: rtl/program_loader_if.sv
// program_loader_if: UART byte stream, ack transmit and instruction-memory write port of the boot loader
interface program_loader_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        i_tx_busy;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_mem_reset;
    logic        o_push;
    logic [31:0] o_push_data;
    logic        o_load_done;
    logic        o_load_err;
    modport slave (
        input  i_rx_valid, i_rx_data, i_tx_busy,
        output o_tx_start, o_tx_data, o_mem_reset, o_push, o_push_data, o_load_done, o_load_err
    );
    modport master (
        output i_rx_valid, i_rx_data, i_tx_busy,
        input  o_tx_start, o_tx_data, o_mem_reset, o_push, o_push_data, o_load_done, o_load_err
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a UART program image into 32-bit words and pushes them into instruction memory
module program_loader #(
    parameter logic [31:0] INSTR_MEM_SIZE = 32'h8000,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input logic             i_clock,
    input logic             i_reset,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {HDR, DATA, ACK, DONE, ERR} state_t;
    state_t      r_state, w_state;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word, w_word;
    logic [31:0] r_remaining, w_remaining;
    logic        r_tx_sent, w_tx_sent;
    logic        r_tx_start, w_tx_start;
    logic [7:0]  r_tx_data, w_tx_data;
    logic        r_mem_reset, w_mem_reset;
    logic        r_push, w_push;
    logic [31:0] r_push_data, w_push_data;
    logic        r_load_done, r_load_err;
    logic        w_take, w_last;
    logic [31:0] w_full;
    assign w_take = bus.i_rx_valid && (r_state == HDR || r_state == DATA);
    assign w_last = w_take && r_byte_idx == 2'd3;
    assign w_full = {bus.i_rx_data, r_word[23:0]};
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= HDR;
            r_byte_idx  <= 2'd0;
            r_word      <= 32'd0;
            r_remaining <= 32'd0;
            r_tx_sent   <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_mem_reset <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 32'd0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_byte_idx  <= w_take ? r_byte_idx + 2'd1 : r_byte_idx;
            r_word      <= w_word;
            r_remaining <= w_remaining;
            r_tx_sent   <= w_tx_sent;
            r_tx_start  <= w_tx_start;
            r_tx_data   <= w_tx_data;
            r_mem_reset <= w_mem_reset;
            r_push      <= w_push;
            r_push_data <= w_push_data;
            r_load_done <= w_state == DONE;
            r_load_err  <= w_state == ERR;
        end
    end
    always_comb begin
        w_state     = r_state;
        w_word      = r_word;
        w_remaining = r_remaining;
        w_tx_sent   = r_tx_sent;
        w_tx_start  = 1'b0;
        w_tx_data   = r_tx_data;
        w_mem_reset = 1'b0;
        w_push      = 1'b0;
        w_push_data = r_push_data;
        if (w_take)
            w_word[{r_byte_idx, 3'b000} +: 8] = bus.i_rx_data;
        case (r_state)
            HDR: if (w_last) begin
                if (w_full > INSTR_MEM_SIZE)
                    w_state = ERR;
                else begin
                    w_mem_reset = 1'b1;
                    w_remaining = w_full;
                    w_state     = (w_full == 32'd0) ? ACK : DATA;
                end
            end
            DATA: if (w_last) begin
                w_push      = 1'b1;
                w_push_data = w_full;
                w_remaining = r_remaining - 32'd1;
                w_state     = (r_remaining == 32'd1) ? ACK : DATA;
            end
            ACK: if (!bus.i_tx_busy) begin
                w_tx_start = 1'b1;
                w_tx_data  = ACK_BYTE;
                w_state    = DONE;
            end
            // ERR never leaves, so a flag keeps the error byte to a single send
            ERR: if (!bus.i_tx_busy && !r_tx_sent) begin
                w_tx_start = 1'b1;
                w_tx_data  = ERR_BYTE;
                w_tx_sent  = 1'b1;
            end
            default: ;
        endcase
    end
    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_mem_reset = r_mem_reset;
    assign bus.o_push      = r_push;
    assign bus.o_push_data = r_push_data;
    assign bus.o_load_done = r_load_done;
    assign bus.o_load_err  = r_load_err;
endmodule
